// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Requester indices match the bit positions of req/grant/done.
package cpu_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] REQ_IF  = 2'd0;
    localparam logic [1:0] REQ_MEM = 2'd1;
    localparam logic [1:0] REQ_MUL = 2'd2;
    localparam logic [1:0] REQ_DBG = 2'd3;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational 4-way rotating priority picker.
// Search starts at i_ptr and wraps 3->0; i_ptr=0 gives fixed priority.
module rr_pick4
    import cpu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [1:0]         o_idx,
    output logic               o_valid
);

    logic [NUM_REQ-1:0] w_rot;
    logic [1:0]         w_off;

    // Rotate so that bit 0 is the requester at the pointer
    always_comb begin
        w_rot = i_req;
        unique case (i_ptr)
            2'd0: w_rot = i_req;
            2'd1: w_rot = {i_req[0],   i_req[3:1]};
            2'd2: w_rot = {i_req[1:0], i_req[3:2]};
            2'd3: w_rot = {i_req[2:0], i_req[3]};
            default: w_rot = i_req;
        endcase
    end

    // Lowest set bit of the rotated vector is the winner's offset
    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign o_idx   = i_ptr + w_off;
    assign o_valid = |i_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between IF, MEM, M-unit and debug.
// Grants one requester, holds the strobe until ack or watchdog abort.
module mem_port_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_we_in,
    input  logic               i_mem_ack,
    output logic [1:0]         o_sel,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [NUM_REQ-1:0] o_done,
    output logic [NUM_REQ-1:0] o_busywait,
    output logic               o_timeout_err
);

    arb_state_t         r_state, w_state_nxt;
    logic [1:0]         r_sel, w_sel_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic               r_rd, w_rd_nxt;
    logic               r_wr, w_wr_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [1:0]         w_pick_ptr;
    logic [1:0]         w_idx;
    logic               w_valid;
    logic               w_timeout;

    assign w_pick_ptr = (ROUND_ROBIN != 0) ? r_ptr : 2'd0;
    assign w_timeout  = (TIMEOUT != 0) &&
                        (r_cnt == CNT_W'(TIMEOUT - 1));

    rr_pick4 u_pick (
        .i_req   (i_req),
        .i_ptr   (w_pick_ptr),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // State and output registers; reset abandons any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_sel   <= 2'd0;
            r_grant <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: grant in IDLE, complete on ack or watchdog in BUSY
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_done_nxt  = '0;
        w_err_nxt   = r_err;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                w_grant_nxt = '0;
                w_rd_nxt    = 1'b0;
                w_wr_nxt    = 1'b0;
                if (w_valid) begin
                    w_sel_nxt   = w_idx;
                    w_grant_nxt = onehot4(w_idx);
                    w_wr_nxt    = i_we_in[w_idx];
                    w_rd_nxt    = ~i_we_in[w_idx];
                    w_ptr_nxt   = w_idx + 2'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (i_mem_ack || w_timeout) begin
                    w_done_nxt  = onehot4(r_sel);
                    w_grant_nxt = '0;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ARB_IDLE;
                    if (!i_mem_ack) w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign o_sel         = r_sel;
    assign o_grant       = r_grant;
    assign o_mem_read    = r_rd;
    assign o_mem_write   = r_wr;
    assign o_done        = r_done;
    assign o_timeout_err = r_err;
    assign o_busywait    = i_req & ~r_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: rotating and fixed priority,
// ack/timeout completion, boundary cases and async reset.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req, we;
    logic       ack;
    logic [1:0] sel;
    logic [3:0] grant, done, bw;
    logic       rd, wr, err;

    logic [3:0] f_req, f_we;
    logic       f_ack;
    logic [1:0] f_sel;
    logic [3:0] f_grant, f_done, f_bw;
    logic       f_rd, f_wr, f_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4), .CNT_W(8)) u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (req),
        .i_we_in       (we),
        .i_mem_ack     (ack),
        .o_sel         (sel),
        .o_grant       (grant),
        .o_mem_read    (rd),
        .o_mem_write   (wr),
        .o_done        (done),
        .o_busywait    (bw),
        .o_timeout_err (err)
    );

    mem_port_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(4), .CNT_W(8)) u_fx (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (f_req),
        .i_we_in       (f_we),
        .i_mem_ack     (f_ack),
        .o_sel         (f_sel),
        .o_grant       (f_grant),
        .o_mem_read    (f_rd),
        .o_mem_write   (f_wr),
        .o_done        (f_done),
        .o_busywait    (f_bw),
        .o_timeout_err (f_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"},   {30'd0, sel}, 32'd0);
        chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
        chk({tag, "_rdwr"},  {30'd0, rd, wr}, 32'd0);
        chk({tag, "_done"},  {28'd0, done}, 32'd0);
        chk({tag, "_err"},   {31'd0, err}, 32'd0);
    endtask

    initial begin
        req = 4'b0; we = 4'b0; ack = 1'b0;
        f_req = 4'b0; f_we = 4'b0; f_ack = 1'b0;

        // reset state
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        // all four held, rotating order 0,1,2,3,0
        req = 4'b1111;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", {28'd0, grant}, 32'd1 << (i % 4));
            chk("rr_sel", {30'd0, sel}, i % 4);
            ack = 1'b1;
            tick;
            ack = 1'b0;
            chk("rr_done", {28'd0, done}, 32'd1 << (i % 4));
            chk("rr_gap", {28'd0, grant}, 32'd0);
            if (i == 4) req = 4'b0;
            tick;
        end

        // single read, ack after 3 cycles
        req = 4'b0010; we = 4'b0;
        tick;
        chk("rd_grant", {28'd0, grant}, 32'h2);
        chk("rd_sel", {30'd0, sel}, 32'd1);
        chk("rd_strobe1", {30'd0, rd, wr}, 32'h2);
        chk("rd_bw", {28'd0, bw}, 32'h2);
        tick;
        chk("rd_strobe2", {30'd0, rd, wr}, 32'h2);
        tick;
        chk("rd_strobe3", {30'd0, rd, wr}, 32'h2);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("rd_done", {28'd0, done}, 32'h2);
        chk("rd_bw_done", {28'd0, bw}, 32'h0);
        chk("rd_strobe_off", {30'd0, rd, wr}, 32'h0);
        req = 4'b0;
        tick;
        chk("rd_done_1cyc", {28'd0, done}, 32'h0);

        // ack while idle is ignored
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("idle_ack_done", {28'd0, done}, 32'h0);
        chk("idle_ack_grant", {28'd0, grant}, 32'h0);

        // req drops mid-transfer, ack on final timeout cycle
        req = 4'b0001;
        tick;
        chk("co_grant", {28'd0, grant}, 32'h1);
        req = 4'b0;
        tick;
        tick;
        tick;
        chk("co_hold", {28'd0, grant}, 32'h1);
        chk("co_nodone", {28'd0, done}, 32'h0);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("co_done", {28'd0, done}, 32'h1);
        chk("co_err", {31'd0, err}, 32'd0);
        tick;

        // write, we_in change and new req ignored, then timeout
        req = 4'b1000; we = 4'b1000;
        tick;
        chk("to_grant", {28'd0, grant}, 32'h8);
        chk("to_sel", {30'd0, sel}, 32'd3);
        chk("to_strobe", {30'd0, rd, wr}, 32'h1);
        we = 4'b0000; req = 4'b1001;
        tick;
        tick;
        chk("to_we_hold", {30'd0, rd, wr}, 32'h1);
        chk("to_grant_hold", {28'd0, grant}, 32'h8);
        tick;
        chk("to_nodone", {28'd0, done}, 32'h0);
        tick;
        chk("to_done", {28'd0, done}, 32'h8);
        chk("to_err", {31'd0, err}, 32'd1);
        req = 4'b0001;
        tick;
        chk("to_next_grant", {28'd0, grant}, 32'h1);
        chk("to_err_sticky", {31'd0, err}, 32'd1);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("to_next_done", {28'd0, done}, 32'h1);
        req = 4'b0;
        tick;

        // reset mid-busy clears everything and the pointer
        req = 4'b0001;
        tick;
        chk("rs_grant", {28'd0, grant}, 32'h1);
        req = 4'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rs_async");
        #1;
        req = 4'b0011;
        rst_n = 1'b1;
        tick;
        chk("rs_ptr_grant", {28'd0, grant}, 32'h1);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        req = 4'b0;
        chk("rs_done", {28'd0, done}, 32'h1);
        tick;

        // fixed priority: 2 first, then 1 before 3
        f_req = 4'b1100;
        tick;
        chk("fx_grant2", {28'd0, f_grant}, 32'h4);
        f_req = 4'b1110;
        f_ack = 1'b1;
        tick;
        chk("fx_done2", {28'd0, f_done}, 32'h4);
        f_req = 4'b1010;
        f_ack = 1'b0;
        tick;
        chk("fx_grant1", {28'd0, f_grant}, 32'h2);
        f_ack = 1'b1;
        tick;
        chk("fx_done1", {28'd0, f_done}, 32'h2);
        f_req = 4'b1000;
        f_ack = 1'b0;
        tick;
        chk("fx_grant3", {28'd0, f_grant}, 32'h8);
        f_ack = 1'b1;
        tick;
        f_ack = 1'b0;
        f_req = 4'b0;
        chk("fx_done3", {28'd0, f_done}, 32'h8);
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit data-memory port between four requesters.
- Requesters are IF refill, MEM stage load/store, M-unit spill and debug/DMA.
- Drives the 2-bit select of the 32-bit 4:1 address and write-data muxes, and the memory read/write strobes.
- Returns per-requester busywait/done handshakes.
- Sits between the pipeline stages and the memory model/cache.

Parameters:
- ROUND_ROBIN, 1: 1 = rotating priority; 0 = fixed priority, lowest index wins.
- TIMEOUT, 255: cycles allowed in BUSY before abort; 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  4  request per requester, held high until its done pulse
- we_in  in  4  per requester: 1 = write, 0 = read; sampled at grant
- mem_ack  in  1  one-cycle completion pulse from memory
- sel  out  2  registered mux select for the address and write-data muxes; equals the granted index
- grant  out  4  registered one-hot grant; all zero when idle
- mem_read  out  1  registered read strobe to memory
- mem_write  out  1  registered write strobe to memory
- done  out  4  registered one-cycle completion pulse, one-hot
- busywait  out  4  per requester: busywait[i] = req[i] & ~done[i]
- timeout_err  out  1  sticky flag, set on any watchdog abort

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- States: IDLE and BUSY, held in a registered state register.
- Reset (asynchronous, rst_n low): state=IDLE, sel=0, grant=0, mem_read=0, mem_write=0, done=0, timeout_err=0, rr pointer=0, watchdog count=0.
- IDLE:
  - If any req bit is high, pick a winner.
  - ROUND_ROBIN=1: search starts at the rr pointer and wraps 3->0.
  - ROUND_ROBIN=0: lowest index wins.
  - At the next edge: sel=winner, grant=onehot(winner), mem_write=we_in[winner], mem_read=~we_in[winner], state=BUSY, count=0.
  - rr pointer = (winner+1) mod 4.
  - If no req is high: stay IDLE with all strobes low.
- BUSY:
  - sel, grant and the strobe are held stable.
  - count increments by 1 per cycle.
  - When mem_ack=1, at the next edge: done[sel]=1 for one cycle, grant=0, strobes=0, state=IDLE.
  - When count==TIMEOUT-1 with no ack (TIMEOUT≠0): same exit as ack, plus timeout_err=1.
- Latency:
  - req seen at edge N -> grant and strobe valid after edge N+1.
  - ack at cycle K -> done pulse in cycle K+1.
  - Next grant earliest at edge K+2. The mandatory one IDLE cycle between transactions is intended.
- Boundary rules:
  - mem_ack in IDLE: ignored.
  - ack and timeout in the same cycle: ack wins; timeout_err is not set.
  - Granted req drops mid-transaction: the transaction completes and done still pulses.
  - New req bits arriving during BUSY: no effect until IDLE.
  - we_in changes after grant: ignored.
  - rr pointer wraps 3->0. Pointer is updated on grant, not on completion.
  - rst_n low mid-BUSY: immediate return to reset values; any in-flight memory operation is abandoned.
  - done is one-hot or zero; grant is one-hot or zero. Both hold at every cycle.

Decomposition:
- Shared package cpu_arb_pkg holds:
  - state encoding (ARB_IDLE=1'b0, ARB_BUSY=1'b1)
  - NUM_REQ=4
  - requester index constants REQ_IF=0, REQ_MEM=1, REQ_MUL=2, REQ_DBG=3
- One sub-module: rr_pick4. It is the combinational 4-way priority picker, with inputs req and pointer and outputs winner index and valid. The fixed-priority mode forces pointer=0.
- The muxes themselves stay outside the block and are driven by sel.

Test Plan:
- Single read: req=4'b0010, we_in=0, ack 3 cycles after grant -> sel=1, grant=0010, mem_read high for 3 cycles, done=0010 for one cycle, busywait[1] low after done.
- All four req held high, ack 1 cycle after each grant, ROUND_ROBIN=1 -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- ROUND_ROBIN=0, req=4'b1100 then 4'b1110 held -> grant order 2, then 1 (after 2 completes), never 3 while 1 or 2 pending.
- Timeout, TIMEOUT=4, no ack -> done pulses 4 cycles after grant, timeout_err=1 and stays set, next request is still served.
- Ack coincident with the final timeout cycle -> done pulses, timeout_err stays 0.
- rst_n asserted low mid-BUSY -> all outputs 0 immediately. After release, req=4'b0001 is granted with pointer reset, i.e. index 0 served first.
